// File: rtl/pet2001io_arb.sv
`default_nettype none
// ============================================================================
// Module   : pet2001io_arb
// Purpose  : Arbiter/sequencer for the PET I/O register space (PIA1, PIA2,
//            VIA). Shares one device bus between the 6502 CPU (absolute
//            priority, ce-slot driven) and a secondary host port that is
//            fitted into the idle clocks between CPU cycles.
// Options  : PETIO_ARB_HOST_WR_EN - when defined, host writes reach the
//            devices; when undefined, a host write is acknowledged without a
//            strobe and returns 8'hFF.
// Revision : 1.0 - initial release
// ============================================================================
module pet2001io_arb (
  input  logic        clk,
  input  logic        reset_n,
  // CPU side
  input  logic        ce,
  input  logic        cpu_sel,
  input  logic [10:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  // Host side
  input  logic        host_req,
  input  logic [10:0] host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_din,
  output logic        host_ack,
  output logic [7:0]  host_dout,
  // Device side
  output logic        io_strobe,
  output logic [10:0] io_addr,
  output logic        io_we,
  output logic [7:0]  io_din,
  input  logic [7:0]  io_dout,
  // Status
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPU_STB  = 3'd1;
  localparam logic [2:0] S_CPU_CAP  = 3'd2;
  localparam logic [2:0] S_HOST_STB = 3'd3;
  localparam logic [2:0] S_HOST_CAP = 3'd4;

  localparam logic [7:0] C_HOST_WR_BLOCKED = 8'hFF;

  logic [2:0]  r_state;
  logic [2:0]  w_next;

  // Latched CPU request (captured at every ce)
  logic        r_cpu_pend;
  logic [10:0] r_cpu_addr;
  logic        r_cpu_we;
  logic [7:0]  r_cpu_din;

  // Host transaction attributes latched at grant
  logic        r_host_we;
  logic        r_host_skip;

  // Hold registers for the device address/data between strobes
  logic [10:0] r_io_addr;
  logic [7:0]  r_io_din;

  logic [7:0]  r_cpu_dout;
  logic [7:0]  r_host_dout;

  logic        w_cpu_hit;
  logic        w_host_wr_skip;
  logic        w_host_grant;
  logic [7:0]  w_host_cap_val;

  assign w_cpu_hit = ce & cpu_sel;

`ifdef PETIO_ARB_HOST_WR_EN
  assign w_host_wr_skip = 1'b0;
`else
  // Host writes are suppressed: they bypass the strobe state entirely
  assign w_host_wr_skip = host_we;
`endif

  // Host is only granted in IDLE with no CPU work pending or arriving
  assign w_host_grant = (r_state == S_IDLE) & ~r_cpu_pend & ~w_cpu_hit
                        & host_req & ~ce;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: CPU first, host only in a clk without ce
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_cpu_pend || w_cpu_hit) begin
          w_next = S_CPU_STB;
        end else if (host_req && !ce) begin
          w_next = w_host_wr_skip ? S_HOST_CAP : S_HOST_STB;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CPU_STB:  w_next = S_CPU_CAP;
      S_CPU_CAP:  w_next = S_IDLE;
      S_HOST_STB: w_next = S_HOST_CAP;
      S_HOST_CAP: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output decode: device bus, host handshake and status from current state
  always_comb begin
    io_strobe = 1'b0;
    io_we     = 1'b0;
    io_addr   = r_io_addr;
    io_din    = r_io_din;
    host_ack  = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_CPU_STB: begin
        io_strobe = 1'b1;
        io_we     = r_cpu_we;
        io_addr   = r_cpu_addr;
        io_din    = r_cpu_din;
      end
      S_HOST_STB: begin
        io_strobe = 1'b1;
        io_we     = r_host_we;
        io_addr   = host_addr;
        io_din    = host_din;
      end
      S_HOST_CAP: begin
        host_ack  = 1'b1;
      end
      default: begin
        io_strobe = 1'b0;
      end
    endcase
  end

  // Value presented to the host in HOST_CAP; forwarded so it is valid with ack
  always_comb begin
    w_host_cap_val = r_host_dout;
    if (r_host_skip) begin
      w_host_cap_val = C_HOST_WR_BLOCKED;
    end else if (!r_host_we) begin
      w_host_cap_val = io_dout;
    end
  end

  assign host_dout = (r_state == S_HOST_CAP) ? w_host_cap_val : r_host_dout;
  assign cpu_dout  = r_cpu_dout;

  // CPU request latch: every ce snapshots the bus, CPU_STB retires it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_pend <= 1'b0;
      r_cpu_addr <= 11'd0;
      r_cpu_we   <= 1'b0;
      r_cpu_din  <= 8'd0;
    end else if (ce) begin
      r_cpu_pend <= cpu_sel;
      r_cpu_addr <= cpu_addr;
      r_cpu_we   <= cpu_we;
      r_cpu_din  <= cpu_din;
    end else if (r_state == S_CPU_STB) begin
      r_cpu_pend <= 1'b0;
    end
  end

  // Host attributes frozen at grant so a late host_req drop cannot disturb CAP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_host_we   <= 1'b0;
      r_host_skip <= 1'b0;
    end else if (w_host_grant) begin
      r_host_we   <= host_we;
      r_host_skip <= w_host_wr_skip;
    end
  end

  // Device address/data hold their last strobed values between accesses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_io_addr <= 11'd0;
      r_io_din  <= 8'd0;
    end else if (io_strobe) begin
      r_io_addr <= io_addr;
      r_io_din  <= io_din;
    end
  end

  // Read-data capture for whichever requester owns the CAP slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_dout  <= 8'd0;
      r_host_dout <= 8'd0;
    end else begin
      if ((r_state == S_CPU_CAP) && !r_cpu_we) begin
        r_cpu_dout <= io_dout;
      end
      if (r_state == S_HOST_CAP) begin
        r_host_dout <= w_host_cap_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pet2001io_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pet2001io_arb
// Purpose  : Directed self-checking bench for pet2001io_arb. Honors
//            PETIO_ARB_HOST_WR_EN for the host-write scenario.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pet2001io_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic        cpu_sel = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic        host_req = 1'b0;
  logic [10:0] host_addr = '0;
  logic        host_we = 1'b0;
  logic [7:0]  host_din = '0;
  logic [7:0]  io_dout = '0;
  wire  [7:0]  cpu_dout;
  wire         host_ack;
  wire  [7:0]  host_dout;
  wire         io_strobe;
  wire  [10:0] io_addr;
  wire         io_we;
  wire  [7:0]  io_din;
  wire         busy;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int stb_cnt = 0;
  int base_ack, base_stb;
  logic [7:0] dev_rd = 8'h00;

  pet2001io_arb dut (
    .clk(clk), .reset_n(reset_n),
    .ce(ce), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we),
    .host_din(host_din), .host_ack(host_ack), .host_dout(host_dout),
    .io_strobe(io_strobe), .io_addr(io_addr), .io_we(io_we),
    .io_din(io_din), .io_dout(io_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Device model: registered read data the clk after a read strobe
  always @(posedge clk) begin
    if (io_strobe && !io_we) io_dout <= dev_rd;
    if (host_ack) ack_cnt <= ack_cnt + 1;
    if (io_strobe) stb_cnt <= stb_cnt + 1;
  end

  // Advance one clk; outputs of the new cycle are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ce = 1'($urandom); cpu_sel = 1'($urandom); cpu_addr = 11'($urandom);
      cpu_we = 1'($urandom); cpu_din = 8'($urandom);
      host_req = 1'($urandom); host_addr = 11'($urandom);
      host_we = 1'($urandom); host_din = 8'($urandom);
      cyc();
      total++;
      if ({io_strobe, io_we, io_addr, io_din, cpu_dout, host_dout, host_ack, busy} !== 39'd0) begin
        bad++;
        $display("FAIL reset_outputs got=%h exp=0", {io_strobe, io_we, io_addr, io_din, cpu_dout, host_dout, host_ack, busy});
      end
    end
    ce = 0; cpu_sel = 0; cpu_we = 0; host_req = 0; host_we = 0;
    cpu_addr = '0; cpu_din = '0; host_addr = '0; host_din = '0;
    cyc();
    reset_n = 1'b1;
    base_stb = stb_cnt;
    repeat (4) cyc();
    total++;
    if (stb_cnt - base_stb !== 0) begin
      bad++; $display("FAIL reset_idle_strobes got=%0d exp=0", stb_cnt - base_stb);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_cpu_read();
    dev_rd = 8'h5A;
    cyc();                                   // N
    ce = 1; cpu_sel = 1; cpu_addr = 11'h012; cpu_we = 0; cpu_din = 8'h00;
    cyc();                                   // N+1
    ce = 0; cpu_sel = 0;
    total++;
    if ({io_strobe, io_we, io_addr} !== {1'b1, 1'b0, 11'h012}) begin
      bad++; $display("FAIL cpu_read_strobe got=%b/%b/%h exp=1/0/012", io_strobe, io_we, io_addr);
    end
    cyc();                                   // N+2
    total++;
    if ({io_strobe, cpu_dout} !== {1'b0, 8'h00}) begin
      bad++; $display("FAIL cpu_read_early got=%b/%h exp=0/00", io_strobe, cpu_dout);
    end
    cyc();                                   // N+3
    total++;
    if ({cpu_dout, busy} !== {8'h5A, 1'b0}) begin
      bad++; $display("FAIL cpu_read_data got=%h/%b exp=5a/0", cpu_dout, busy);
    end
  endtask

  task automatic test_collision();
    dev_rd = 8'h3C;
    cyc();                                   // N: both request
    ce = 1; cpu_sel = 1; cpu_we = 1; cpu_addr = 11'h7FF; cpu_din = 8'h33;
    host_req = 1; host_we = 0; host_addr = 11'h010;
    base_ack = ack_cnt;
    cyc();                                   // N+1: CPU strobe
    ce = 0; cpu_sel = 0; cpu_we = 0;
    total++;
    if ({io_strobe, io_we, io_addr, io_din} !== {1'b1, 1'b1, 11'h7FF, 8'h33}) begin
      bad++; $display("FAIL coll_cpu_strobe got=%b/%b/%h/%h exp=1/1/7ff/33", io_strobe, io_we, io_addr, io_din);
    end
    cyc();                                   // N+2: CPU_CAP, bus holds
    total++;
    if ({io_strobe, io_we, io_addr, io_din} !== {1'b0, 1'b0, 11'h7FF, 8'h33}) begin
      bad++; $display("FAIL coll_hold got=%b/%b/%h/%h exp=0/0/7ff/33", io_strobe, io_we, io_addr, io_din);
    end
    cyc();                                   // N+3: IDLE grants host
    total++;
    if ({io_strobe, busy} !== 2'b00) begin
      bad++; $display("FAIL coll_idle got=%b/%b exp=0/0", io_strobe, busy);
    end
    cyc();                                   // N+4: host strobe
    total++;
    if ({io_strobe, io_we, io_addr} !== {1'b1, 1'b0, 11'h010}) begin
      bad++; $display("FAIL coll_host_strobe got=%b/%b/%h exp=1/0/010", io_strobe, io_we, io_addr);
    end
    cyc();                                   // N+5: host ack
    total++;
    if ({host_ack, host_dout} !== {1'b1, 8'h3C}) begin
      bad++; $display("FAIL coll_host_ack got=%b/%h exp=1/3c", host_ack, host_dout);
    end
    host_req = 0;
    repeat (3) cyc();
    total++;
    if (ack_cnt - base_ack !== 1) begin
      bad++; $display("FAIL coll_ack_count got=%0d exp=1", ack_cnt - base_ack);
    end
    total++;
    if (cpu_dout !== 8'h5A) begin
      bad++; $display("FAIL coll_cpu_write_keeps_dout got=%h exp=5a", cpu_dout);
    end
  endtask

  task automatic test_cpu_during_host();
    dev_rd = 8'hC3;
    cyc();                                   // H
    host_req = 1; host_we = 0; host_addr = 11'h020;
    cyc();                                   // H+1: HOST_STB, ce arrives
    total++;
    if ({io_strobe, io_addr} !== {1'b1, 11'h020}) begin
      bad++; $display("FAIL cdh_host_strobe got=%b/%h exp=1/020", io_strobe, io_addr);
    end
    ce = 1; cpu_sel = 1; cpu_we = 1; cpu_addr = 11'h155; cpu_din = 8'h9E;
    cyc();                                   // H+2: HOST_CAP
    ce = 0; cpu_sel = 0; cpu_we = 0; cpu_addr = 11'h000; cpu_din = 8'h00;
    total++;
    if ({host_ack, host_dout} !== {1'b1, 8'hC3}) begin
      bad++; $display("FAIL cdh_host_ack got=%b/%h exp=1/c3", host_ack, host_dout);
    end
    host_req = 0;
    cyc();                                   // H+3: IDLE
    total++;
    if ({io_strobe, host_ack} !== 2'b00) begin
      bad++; $display("FAIL cdh_idle got=%b/%b exp=0/0", io_strobe, host_ack);
    end
    cyc();                                   // H+4: CPU strobe from pend
    total++;
    if ({io_strobe, io_we, io_addr, io_din} !== {1'b1, 1'b1, 11'h155, 8'h9E}) begin
      bad++; $display("FAIL cdh_cpu_strobe got=%b/%b/%h/%h exp=1/1/155/9e", io_strobe, io_we, io_addr, io_din);
    end
    cyc(); cyc();                            // H+6
    total++;
    if ({busy, host_dout} !== {1'b0, 8'hC3}) begin
      bad++; $display("FAIL cdh_end got=%b/%h exp=0/c3", busy, host_dout);
    end
  endtask

  task automatic test_host_write();
    cyc();                                   // H
    host_req = 1; host_we = 1; host_addr = 11'h040; host_din = 8'hA5;
    base_ack = ack_cnt; base_stb = stb_cnt;
`ifdef PETIO_ARB_HOST_WR_EN
    cyc();                                   // H+1: strobe
    total++;
    if ({io_strobe, io_we, io_addr, io_din} !== {1'b1, 1'b1, 11'h040, 8'hA5}) begin
      bad++; $display("FAIL hw_strobe got=%b/%b/%h/%h exp=1/1/040/a5", io_strobe, io_we, io_addr, io_din);
    end
    cyc();                                   // H+2: ack
    total++;
    if ({host_ack, host_dout} !== {1'b1, 8'hC3}) begin
      bad++; $display("FAIL hw_ack got=%b/%h exp=1/c3", host_ack, host_dout);
    end
    host_req = 0; host_we = 0;
    repeat (2) cyc();
    total++;
    if ((stb_cnt - base_stb !== 1) || (ack_cnt - base_ack !== 1)) begin
      bad++; $display("FAIL hw_counts got=%0d/%0d exp=1/1", stb_cnt - base_stb, ack_cnt - base_ack);
    end
`else
    cyc();                                   // H+1: HOST_CAP directly
    total++;
    if ({io_strobe, host_ack, host_dout} !== {1'b0, 1'b1, 8'hFF}) begin
      bad++; $display("FAIL hw_blocked_ack got=%b/%b/%h exp=0/1/ff", io_strobe, host_ack, host_dout);
    end
    host_req = 0; host_we = 0;
    repeat (2) cyc();
    total++;
    if ((stb_cnt - base_stb !== 0) || (ack_cnt - base_ack !== 1)) begin
      bad++; $display("FAIL hw_blocked_counts got=%0d/%0d exp=0/1", stb_cnt - base_stb, ack_cnt - base_ack);
    end
    total++;
    if (host_dout !== 8'hFF) begin
      bad++; $display("FAIL hw_blocked_hold got=%h exp=ff", host_dout);
    end
`endif
  endtask

  task automatic test_abort();
    // Host request blocked by ce (cpu_sel=0), then dropped before grant
    cyc();
    ce = 1; cpu_sel = 0; host_req = 1; host_we = 0; host_addr = 11'h030;
    base_ack = ack_cnt; base_stb = stb_cnt;
    cyc();
    ce = 0; host_req = 0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_drop_busy got=%b exp=0", busy);
    end
    repeat (3) cyc();
    total++;
    if ((stb_cnt - base_stb !== 0) || (ack_cnt - base_ack !== 0) || (busy !== 1'b0)) begin
      bad++; $display("FAIL abort_drop got=%0d/%0d/%b exp=0/0/0", stb_cnt - base_stb, ack_cnt - base_ack, busy);
    end
    // Reset asserted during HOST_STB
    host_req = 1;
    base_ack = ack_cnt;
    cyc();                                   // HOST_STB
    total++;
    if (io_strobe !== 1'b1) begin
      bad++; $display("FAIL abort_rst_stb got=%b exp=1", io_strobe);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({io_strobe, busy, host_ack, io_addr} !== {1'b0, 1'b0, 1'b0, 11'h000}) begin
      bad++; $display("FAIL abort_rst_clear got=%b/%b/%b/%h exp=0/0/0/000", io_strobe, busy, host_ack, io_addr);
    end
    host_req = 0;
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    total++;
    if ((ack_cnt - base_ack !== 0) || (busy !== 1'b0)) begin
      bad++; $display("FAIL abort_rst_after got=%0d/%b exp=0/0", ack_cnt - base_ack, busy);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_collision();
    test_cpu_during_host();
    test_host_write();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
